// File: rtl/axi_wr_burst_gen.sv
// AXI write burst generator: one command -> AW request, len+1 patterned beats, B response.
// Define WR_TIMEOUT_EN to bound the response wait to TIMEOUT_CYC cycles.
module axi_wr_burst_gen #(
  parameter int AW          = 32,
  parameter int DW          = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            axi_aclk,
  input  logic            axi_aresetn,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [2:0]      cmd_size,
  input  logic [1:0]      cmd_burst,
  input  logic [DW-1:0]   cmd_seed,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic [AW-1:0]   gen_awaddr,
  output logic [7:0]      gen_awlen,
  output logic [2:0]      gen_awsize,
  output logic [1:0]      gen_awburst,
  output logic            gen_awvalid,
  input  logic            axi_awready,
  output logic [DW-1:0]   gen_wdata,
  output logic [DW/8-1:0] gen_wstrb,
  output logic            gen_wlast,
  output logic            gen_wvalid,
  input  logic            axi_wready,
  input  logic            axi_bvalid,
  input  logic [1:0]      axi_bresp,
  output logic            gen_bready,
  output logic            done,
  output logic [1:0]      status,
  output logic            err
);

  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] seed_q;
  logic [7:0]    idx;
  logic [1:0]    bresp_q;
  logic          gen_err_q;
  logic          bad_wrap;

  logic [7:0]    nidx;
  logic [AW-1:0] step;
  logic [AW-1:0] wmask;
  logic [AW-1:0] nadr;
  logic [3:0]    nbytes;
  logic [2:0]    off;
  logic [SW-1:0] nstrb;
  logic [DW-1:0] ndata;

`ifdef WR_TIMEOUT_EN
  logic [31:0]   to_cnt;
`endif

  assign bad_wrap = (cmd_burst == 2'b10) &&
    !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15});

  // Next beat's address/strobe/data, computed from the latched AW fields
  always_comb begin
    nidx   = (state == S_DATA) ? idx + 8'd1 : 8'd0;
    step   = AW'(nidx) << gen_awsize;
    wmask  = (AW'({1'b0, gen_awlen} + 9'd1) << gen_awsize) - AW'(1);
    nadr   = gen_awaddr + step;
    unique case (1'b1)
      (gen_awburst == 2'b00): nadr = gen_awaddr;
      (gen_awburst == 2'b10): nadr = (gen_awaddr & ~wmask)
                                   | ((gen_awaddr + step) & wmask);
      default: nadr = gen_awaddr + step;
    endcase
    nbytes = 4'd1 << gen_awsize;
    off    = nadr[2:0] & ~3'(nbytes - 4'd1);
    nstrb  = SW'((16'd1 << nbytes) - 16'd1) << off;
    // Unaligned INCR start: drop lane bytes below the start address
    if (gen_awburst == 2'b01 && nidx == 8'd0)
      nstrb = nstrb & (SW'('1) << nadr[2:0]);
    ndata  = seed_q + DW'(nidx);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      gen_awaddr  <= '0;
      gen_awlen   <= '0;
      gen_awsize  <= '0;
      gen_awburst <= '0;
      gen_awvalid <= 1'b0;
      gen_wdata   <= '0;
      gen_wstrb   <= '0;
      gen_wlast   <= 1'b0;
      gen_wvalid  <= 1'b0;
      gen_bready  <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
      err         <= 1'b0;
      seed_q      <= '0;
      idx         <= '0;
      bresp_q     <= 2'b00;
      gen_err_q   <= 1'b0;
`ifdef WR_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            gen_awaddr  <= cmd_addr;
            gen_awlen   <= cmd_len;
            gen_awsize  <= (cmd_size > 3'd3) ? 3'd3 : cmd_size;
            gen_awburst <= bad_wrap ? 2'b01 : cmd_burst;
            seed_q      <= cmd_seed;
            gen_err_q   <= bad_wrap;
            err         <= bad_wrap;
            cmd_ready   <= 1'b0;
            gen_awvalid <= 1'b1;
            state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi_awready) begin
            gen_awvalid <= 1'b0;
            idx         <= 8'd0;
            gen_wdata   <= ndata;
            gen_wstrb   <= nstrb;
            gen_wlast   <= (gen_awlen == 8'd0);
            gen_wvalid  <= 1'b1;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (axi_wready) begin
            if (gen_wlast) begin
              gen_wvalid <= 1'b0;
              gen_wlast  <= 1'b0;
              gen_bready <= 1'b1;
`ifdef WR_TIMEOUT_EN
              to_cnt     <= '0;
`endif
              state      <= S_RESP;
            end else begin
              idx       <= nidx;
              gen_wdata <= ndata;
              gen_wstrb <= nstrb;
              gen_wlast <= (nidx == gen_awlen);
            end
          end
        end
        S_RESP: begin
          if (axi_bvalid) begin
            bresp_q    <= axi_bresp;
            if (axi_bresp != 2'b00) err <= 1'b1;
            gen_bready <= 1'b0;
            state      <= S_DONE;
          end
`ifdef WR_TIMEOUT_EN
          else if (to_cnt == 32'(TIMEOUT_CYC - 1)) begin
            gen_bready <= 1'b0;
            err        <= 1'b1;
            gen_err_q  <= 1'b1;
            state      <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end
        S_DONE: begin
          done      <= 1'b1;
          status    <= gen_err_q ? 2'b11 : bresp_q;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Bench for axi_wr_burst_gen: command table, beat scoreboard, reset corner cases.
module tb_axi_wr_burst_gen;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic [63:0] cmd_seed = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] gen_awaddr;
  logic [7:0]  gen_awlen;
  logic [2:0]  gen_awsize;
  logic [1:0]  gen_awburst;
  logic        gen_awvalid;
  logic        axi_awready = 1'b1;
  logic [63:0] gen_wdata;
  logic [7:0]  gen_wstrb;
  logic        gen_wlast;
  logic        gen_wvalid;
  logic        axi_wready = 1'b1;
  logic        axi_bvalid = 1'b0;
  logic [1:0]  axi_bresp = 2'b00;
  logic        gen_bready;
  logic        done;
  logic [1:0]  status;
  logic        err;

  axi_wr_burst_gen #(.AW(32), .DW(64), .TIMEOUT_CYC(16)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_seed(cmd_seed),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .gen_awaddr(gen_awaddr), .gen_awlen(gen_awlen),
    .gen_awsize(gen_awsize), .gen_awburst(gen_awburst),
    .gen_awvalid(gen_awvalid), .axi_awready(axi_awready),
    .gen_wdata(gen_wdata), .gen_wstrb(gen_wstrb),
    .gen_wlast(gen_wlast), .gen_wvalid(gen_wvalid),
    .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
    .axi_bresp(axi_bresp), .gen_bready(gen_bready),
    .done(done), .status(status), .err(err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int cyc = 0;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] seed;
    logic [1:0]  bresp;
    logic        bv;
    int          wmode;
    bit          lat;
    logic [1:0]  e_status;
    logic        e_err;
    logic [1:0]  e_awburst;
    logic [2:0]  e_awsize;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  vec_t        tbl[$];
  beat_t       sbq[$];
  logic [7:0]  slog[$];
  int          wr_mode = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic bit is_bad(input vec_t v);
    return v.burst == 2'b10 &&
      !(v.len == 8'd1 || v.len == 8'd3 || v.len == 8'd7 || v.len == 8'd15);
  endfunction

  // Byte-wise strobe model from the beat address
  function automatic logic [7:0] m_strb(input vec_t v, input int i);
    int sz, n, st, a, win, base, lo, eb;
    logic [7:0] s;
    sz = (v.size > 3'd3) ? 3 : int'(v.size);
    n  = 1 << sz;
    st = int'(v.addr);
    eb = is_bad(v) ? 1 : int'(v.burst);
    if (eb == 0) a = st;
    else if (eb == 2) begin
      win  = (int'(v.len) + 1) * n;
      base = (st / win) * win;
      a    = base + ((st - base + i * n) % win);
    end else a = st + i * n;
    lo = ((a % 8) / n) * n;
    for (int b = 0; b < 8; b++)
      s[b] = (b >= lo) && (b < lo + n) &&
             !(eb == 1 && i == 0 && b < (a % 8));
    return s;
  endfunction

  always @(posedge axi_aclk) begin
    #1;
    case (wr_mode)
      1: axi_wready = ~axi_wready;
      2: axi_wready = 1'b0;
      default: axi_wready = 1'b1;
    endcase
  end

  beat_t       mb;
  logic [63:0] hd;
  logic [7:0]  hs;
  bit          hv = 0;

  always @(negedge axi_aclk) begin
    if (gen_wvalid && axi_aresetn) begin
      if (hv) begin
        chk("stall_data", gen_wdata, hd);
        chk("stall_strb", 64'(gen_wstrb), 64'(hs));
      end
      if (axi_wready) begin
        chk("beat_expected", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
          mb = sbq.pop_front();
          chk("wdata", gen_wdata, mb.d);
          chk("wstrb", 64'(gen_wstrb), 64'(mb.s));
          chk("wlast", 64'(gen_wlast), 64'(mb.l));
        end
        slog.push_back(gen_wstrb);
        hv = 0;
      end else begin
        hv = 1;
        hd = gen_wdata;
        hs = gen_wstrb;
      end
    end else hv = 0;
  end

  task automatic wait_idle();
    int lim = 0;
    while (!cmd_ready && lim < 100) begin
      @(negedge axi_aclk);
      lim++;
    end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
  endtask

  task automatic drive_cmd(input vec_t v);
    @(posedge axi_aclk);
    #1;
    wr_mode    = v.wmode;
    axi_bvalid = v.bv;
    axi_bresp  = v.bresp;
    cmd_addr   = v.addr;
    cmd_len    = v.len;
    cmd_size   = v.size;
    cmd_burst  = v.burst;
    cmd_seed   = v.seed;
    cmd_valid  = 1'b1;
  endtask

  task automatic run(input vec_t v);
    int  t;
    bit  got;
    wait_idle();
    sbq.delete();
    slog.delete();
    drive_cmd(v);
    t = cyc;
    for (int i = 0; i <= int'(v.len); i++)
      sbq.push_back('{d: v.seed + 64'(i), s: m_strb(v, i),
                      l: (i == int'(v.len))});
    @(posedge axi_aclk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 32'hDEAD_BEEF;
    @(negedge axi_aclk);
    chk("awvalid", 64'(gen_awvalid), 64'd1);
    chk("awaddr", 64'(gen_awaddr), 64'(v.addr));
    chk("awlen", 64'(gen_awlen), 64'(v.len));
    chk("awsize", 64'(gen_awsize), 64'(v.e_awsize));
    chk("awburst", 64'(gen_awburst), 64'(v.e_awburst));
    chk("err_on_accept", 64'(err), 64'(is_bad(v)));
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge axi_aclk);
      if (done) got = 1;
    end
    chk("done_seen", 64'(got), 64'd1);
    if (got) begin
      chk("status", 64'(status), 64'(v.e_status));
      chk("err", 64'(err), 64'(v.e_err));
      chk("beats_left", 64'(sbq.size()), 64'd0);
      chk("ready_at_done", 64'(cmd_ready), 64'd1);
      if (v.lat) chk("latency", 64'(cyc - t), 64'(int'(v.len) + 5));
      @(negedge axi_aclk);
      chk("done_pulse", 64'(done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   seen;
    int   lim;
    tbl.push_back('{addr: 32'h1000, len: 8'd3, size: 3'd3, burst: 2'b01,
      seed: 64'h10, bresp: 2'b00, bv: 1'b1, wmode: 0, lat: 1'b1,
      e_status: 2'b00, e_err: 1'b0, e_awburst: 2'b01, e_awsize: 3'd3});
    tbl.push_back('{addr: 32'h1018, len: 8'd3, size: 3'd3, burst: 2'b10,
      seed: 64'h100, bresp: 2'b00, bv: 1'b1, wmode: 0, lat: 1'b1,
      e_status: 2'b00, e_err: 1'b0, e_awburst: 2'b10, e_awsize: 3'd3});
    tbl.push_back('{addr: 32'h2003, len: 8'd1, size: 3'd0, burst: 2'b01,
      seed: 64'h55, bresp: 2'b00, bv: 1'b1, wmode: 0, lat: 1'b1,
      e_status: 2'b00, e_err: 1'b0, e_awburst: 2'b01, e_awsize: 3'd0});
    tbl.push_back('{addr: 32'h2003, len: 8'd2, size: 3'd0, burst: 2'b00,
      seed: 64'h77, bresp: 2'b00, bv: 1'b1, wmode: 0, lat: 1'b1,
      e_status: 2'b00, e_err: 1'b0, e_awburst: 2'b00, e_awsize: 3'd0});
    tbl.push_back('{addr: 32'h3000, len: 8'd4, size: 3'd3, burst: 2'b01,
      seed: 64'hA0, bresp: 2'b10, bv: 1'b1, wmode: 1, lat: 1'b0,
      e_status: 2'b10, e_err: 1'b1, e_awburst: 2'b01, e_awsize: 3'd3});
    tbl.push_back('{addr: 32'h4000, len: 8'd2, size: 3'd2, burst: 2'b10,
      seed: 64'hB0, bresp: 2'b00, bv: 1'b1, wmode: 0, lat: 1'b1,
      e_status: 2'b11, e_err: 1'b1, e_awburst: 2'b01, e_awsize: 3'd2});
    tbl.push_back('{addr: 32'h5004, len: 8'd2, size: 3'd7, burst: 2'b01,
      seed: 64'hFFFF_FFFF_FFFF_FFFF, bresp: 2'b00, bv: 1'b1, wmode: 0,
      lat: 1'b1, e_status: 2'b00, e_err: 1'b0, e_awburst: 2'b01,
      e_awsize: 3'd3});
    tbl.push_back('{addr: 32'h6006, len: 8'd0, size: 3'd1, burst: 2'b01,
      seed: 64'hC0, bresp: 2'b01, bv: 1'b1, wmode: 0, lat: 1'b1,
      e_status: 2'b01, e_err: 1'b1, e_awburst: 2'b01, e_awsize: 3'd1});
`ifdef WR_TIMEOUT_EN
    tbl.push_back('{addr: 32'h8000, len: 8'd0, size: 3'd3, burst: 2'b01,
      seed: 64'h5, bresp: 2'b00, bv: 1'b0, wmode: 0, lat: 1'b0,
      e_status: 2'b11, e_err: 1'b1, e_awburst: 2'b01, e_awsize: 3'd3});
`endif

    repeat (3) @(negedge axi_aclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_awvalid", 64'(gen_awvalid), 64'd0);
    chk("rst_wvalid", 64'(gen_wvalid), 64'd0);
    chk("rst_wlast", 64'(gen_wlast), 64'd0);
    chk("rst_bready", 64'(gen_bready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_awaddr", 64'(gen_awaddr), 64'd0);
    chk("rst_wdata", gen_wdata, 64'd0);
    axi_aresetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i]);
      if (i == 2) begin
        chk("incr_u_nbeats", 64'(slog.size()), 64'd2);
        if (slog.size() == 2) begin
          chk("incr_u_strb0", 64'(slog[0]), 64'h08);
          chk("incr_u_strb1", 64'(slog[1]), 64'h10);
        end
      end
      if (i == 3) begin
        chk("fixed_nbeats", 64'(slog.size()), 64'd3);
        foreach (slog[j]) chk("fixed_strb", 64'(slog[j]), 64'h08);
      end
    end

    // Reset while stalled in the data phase
    v = '{addr: 32'h7000, len: 8'd7, size: 3'd3, burst: 2'b01,
      seed: 64'h1, bresp: 2'b00, bv: 1'b1, wmode: 2, lat: 1'b0,
      e_status: 2'b00, e_err: 1'b0, e_awburst: 2'b01, e_awsize: 3'd3};
    wait_idle();
    sbq.delete();
    sbq.push_back('{d: 64'h1, s: 8'hFF, l: 1'b0});
    drive_cmd(v);
    @(posedge axi_aclk);
    #1;
    cmd_valid = 1'b0;
    lim = 0;
    while (!gen_wvalid && lim < 50) begin
      @(negedge axi_aclk);
      lim++;
    end
    chk("rst_mid_wvalid_up", 64'(gen_wvalid), 64'd1);
    @(posedge axi_aclk);
    #3;
    axi_aresetn = 1'b0;
    #1;
    chk("rst_mid_wvalid", 64'(gen_wvalid), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_mid_wlast", 64'(gen_wlast), 64'd0);
    sbq.delete();
    wr_mode = 0;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge axi_aclk);
      if (done) seen++;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    chk("idle_after_rst", 64'(cmd_ready), 64'd1);
    run(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_gen.md
Name: axi_wr_burst_gen

Overview:
Master-side write-traffic generator that sits directly upstream of the AXI protocol FSM. It accepts one burst command at a time. For each command it drives the write-address request, streams len+1 patterned data beats with correct per-beat strobes, then collects the write response. It reports completion and status to a test/control sequencer.

Parameters:
AW, 32, address width
DW, 64, data width (fixed 64; strobe width DW/8 = 8)
TIMEOUT_CYC, 1024, response-wait limit in cycles (used only with the optional feature)

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
cmd_addr  in  AW  burst start address
cmd_len  in  8  beats minus 1
cmd_size  in  3  log2 bytes per beat
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
cmd_seed  in  64  data pattern seed
cmd_valid  in  1  command valid
cmd_ready  out  1  generator idle, can accept a command
gen_awaddr  out  AW  write address to the protocol FSM
gen_awlen  out  8  burst length
gen_awsize  out  3  burst size
gen_awburst  out  2  burst type
gen_awvalid  out  1  address valid
axi_awready  in  1  address accepted by the protocol FSM
gen_wdata  out  64  beat data
gen_wstrb  out  8  beat strobes
gen_wlast  out  1  final beat
gen_wvalid  out  1  data valid
axi_wready  in  1  beat accepted
axi_bvalid  in  1  response valid
axi_bresp  in  2  response code
gen_bready  out  1  response accept
done  out  1  one-cycle completion pulse
status  out  2  bresp of the last burst, or 2'b11 on a generator error
err  out  1  sticky error flag; cleared by the next accepted command

Behaviour:
- Reset (asynchronous, immediate): state IDLE; cmd_ready=1; gen_awvalid, gen_wvalid, gen_wlast, gen_bready, done, err = 0; status=00; gen_* buses = 0. Reset asserted mid-burst abandons the burst with no completion pulse.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: cmd_ready=1.
  - cmd_valid && cmd_ready: latch the command, clear err, go to ADDR next cycle.
  - Effective size = min(cmd_size, 3).
  - WRAP with cmd_len not in {1,3,7,15}: treat as INCR, set err=1, force status to 11 at DONE.
- ADDR: gen_awvalid=1 with address fields held stable. On gen_awvalid && axi_awready: gen_awvalid=0, beat counter=0, go to DATA. There is no latency bound on axi_awready.
- DATA: gen_wvalid=1.
  - gen_wdata = seed + beat_index, 64-bit wrap-around.
  - Beat address: FIXED = start address; INCR = start + index*2^size; WRAP = wraps within an aligned window of (len+1)*2^size bytes.
  - gen_wstrb = ((1<<2^size)-1) << (beat_addr[2:0] & ~(2^size-1)). The first INCR beat of an unaligned start strobes only bytes at or above addr[2:0] within its size lane.
  - gen_wlast=1 exactly when beat_index==len.
  - Data and strobes stay stable until handshake. On handshake the next beat is presented the following cycle, so back-to-back beats are supported.
  - Handshake on the last beat: gen_wvalid=0, gen_wlast=0, go to RESP.
- RESP: gen_bready=1. On axi_bvalid && gen_bready: capture axi_bresp, set err if bresp!=00, gen_bready=0, go to DONE.
- DONE: done=1 for one cycle; status updated in the same cycle; return to IDLE.
- The address is never issued before the previous response completes, so at most one burst is outstanding.
- An axi_bvalid arriving outside RESP is ignored; gen_bready=0 there.
- cmd_* inputs are ignored while cmd_ready=0.
- Latency: a command accepted at cycle t drives gen_awvalid at t+1. With ready always high, a len=L burst gives done at t+L+5.

Optional Feature:
- WR_TIMEOUT_EN defined: a counter runs in RESP. If TIMEOUT_CYC cycles elapse with no axi_bvalid: gen_bready=0, err=1, status=11, go to DONE. The counter clears on entering RESP.
- Without the macro: RESP waits indefinitely and no counter logic exists.

Test Plan:
- INCR, addr 0x1000, len 3, size 3, seed 0x10, all readies high -> awaddr 0x1000; data 0x10..0x13; wstrb FF each beat; wlast on beat 3; bresp 00 -> done pulse, status 00, err 0.
- WRAP, addr 0x1018, len 3, size 3 -> beat addresses 0x1018, 0x1000, 0x1008, 0x1010; wstrb FF; wlast on beat 3.
- INCR, addr 0x2003, len 1, size 0 -> wstrb 08 then 10; FIXED, same address, len 2 -> wstrb 08 on all 3 beats.
- axi_wready toggled 1-0-1 per cycle -> gen_wdata/gen_wstrb hold stable while stalled; exactly len+1 beats accepted. axi_bresp=10 -> status 10, err 1.
- WRAP with len 2 -> INCR addressing, done with status 11, err 1. Next accepted command clears err. Reset asserted during DATA -> gen_wvalid drops 0 immediately and cmd_ready=1.
- WR_TIMEOUT_EN with TIMEOUT_CYC=16 and axi_bvalid held 0 -> done after 16 RESP cycles, status 11, err 1.
